// File: rtl/wave_pkg.sv
// Shared definitions for the waveform frame-capture block: FSM state
// encoding, default parameter values and fixed field widths.
package wave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam int DEF_DECIM      = 1;
  localparam int DEF_TRIG_LEVEL = 120;
  localparam int DEF_FRAME_LEN  = 64;
  localparam int DEF_DEPTH_BITS = 4;

  // Field widths: strobe counter covers DECIM up to 65535, frame index
  // covers FRAME_LEN up to 4096, FIFO entries are {last, data}.
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 12;
  localparam int ENTRY_W = 9;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO of {last, data} entries with an occupancy
// output. A write to a full FIFO is accepted only when a pop happens in
// the same cycle; otherwise the write is ignored and the caller counts it
// as a drop. The storage array itself carries no reset.
module sample_fifo import wave_pkg::*; #(
  parameter int DEPTH_BITS = DEF_DEPTH_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr,
  input  logic [ENTRY_W-1:0]   i_wdata,
  input  logic                 i_rd,
  output logic [ENTRY_W-1:0]   o_rdata,
  output logic                 o_valid,
  output logic                 o_full,
  output logic [DEPTH_BITS:0]  o_level
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] LP_FULL = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wptr;
  logic [DEPTH_BITS-1:0] r_rptr;
  logic [DEPTH_BITS:0]   r_level;

  logic w_pop;
  logic w_push;

  assign w_pop   = i_rd && (r_level != '0);
  assign w_push  = i_wr && ((r_level != LP_FULL) || w_pop);
  assign o_valid = (r_level != '0);
  assign o_full  = (r_level == LP_FULL);
  assign o_level = r_level;
  // Head is gated to zero while empty so the outputs are defined after reset.
  assign o_rdata = o_valid ? r_mem[r_rptr] : '0;

  // Storage write; no reset needed since only occupied slots are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally modulo the depth; level tracks push/pop balance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + DEPTH_BITS'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_BITS'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (DEPTH_BITS+1)'(1);
        2'b01:   r_level <= r_level - (DEPTH_BITS+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/wave_frame_capture.sv
// Triggered frame capture of a decimated waveform. A start pulse arms the
// block; the first rising crossing of TRIG_LEVEL on a sample strobe starts
// a FRAME_LEN-sample frame that is pushed into a FWFT FIFO. Samples that
// find the FIFO full are dropped but still consume a frame slot.
module wave_frame_capture import wave_pkg::*; #(
  parameter int DECIM      = DEF_DECIM,
  parameter int TRIG_LEVEL = DEF_TRIG_LEVEL,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int DEPTH_BITS = DEF_DEPTH_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          sample_in,
  input  logic                start,
  input  logic                abort,
  output logic [7:0]          m_data,
  output logic                m_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow,
  output logic [15:0]         drop_count,
  output logic [DEPTH_BITS:0] level
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX  = CNT_W'(DECIM - 1);
  localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [7:0]       LP_TRIG     = 8'(TRIG_LEVEL);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_prev;
  logic               r_prev_valid;
  logic [IDX_W-1:0]   r_idx;
  logic               r_frame_done;
  logic               r_overflow;
  logic [15:0]        r_drop_count;

  logic               w_strobe;
  logic               w_start_acc;
  logic               w_trig;
  logic               w_take;
  logic               w_is_last;
  logic               w_frame_end;
  logic               w_pop;
  logic               w_full;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_rdata;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A start is honoured only from IDLE and loses to a coincident abort.
  assign w_strobe    = (r_cnt == '0);
  assign w_start_acc = start && !abort && (r_state == ST_IDLE);
  assign w_trig      = (r_state == ST_ARMED) && w_strobe && r_prev_valid &&
                       (r_prev < LP_TRIG) && (sample_in >= LP_TRIG);
  // The trigger sample is frame sample 0; abort suppresses any write.
  assign w_take      = !abort && (w_trig || ((r_state == ST_CAPTURE) && w_strobe));
  assign w_is_last   = (r_idx == LP_IDX_LAST);
  assign w_frame_end = w_take && w_is_last;
  assign w_pop       = m_valid && m_ready;
  assign w_drop      = w_take && w_full && !w_pop;

  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign m_last     = w_rdata[8];
  assign m_data     = w_rdata[7:0];

  sample_fifo #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wr    (w_take),
    .i_wdata ({w_is_last, sample_in}),
    .i_rd    (m_ready),
    .o_rdata (w_rdata),
    .o_valid (m_valid),
    .o_full  (w_full),
    .o_level (level)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: abort dominates, frame ends on its last slot.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_acc) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (abort)            w_state_nxt = ST_IDLE;
        else if (w_frame_end) w_state_nxt = ST_IDLE;
        else if (w_take)      w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort || w_frame_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobe counter, trigger history, frame index and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_start_acc || (r_cnt == LP_CNT_MAX)) r_cnt <= '0;
      else                                      r_cnt <= r_cnt + CNT_W'(1);

      if (w_strobe) r_prev <= sample_in;
      if (w_start_acc)   r_prev_valid <= 1'b0;
      else if (w_strobe) r_prev_valid <= 1'b1;

      if (w_take)                    r_idx <= w_is_last ? '0 : r_idx + IDX_W'(1);
      else if (r_state != ST_CAPTURE) r_idx <= '0;

      r_frame_done <= w_frame_end;

      if (w_start_acc) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end else if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= sat_inc16(r_drop_count);
      end
    end
  end

endmodule

// File: tb/tb_wave_frame_capture.sv
// Bench for wave_frame_capture: a queue-based behavioural model is
// stepped once per clock and compared against every output, with
// directed scenarios followed by a randomized phase.
module tb_wave_frame_capture;

  localparam int P_DECIM = 2;
  localparam int P_TL    = 120;
  localparam int P_FL    = 10;
  localparam int P_DB    = 2;
  localparam int P_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    sample_in = 8'd0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [7:0]    m_data;
  logic          m_last;
  logic          m_valid;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [P_DB:0] level;

  wave_frame_capture #(
    .DECIM      (P_DECIM),
    .TRIG_LEVEL (P_TL),
    .FRAME_LEN  (P_FL),
    .DEPTH_BITS (P_DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .start      (start),
    .abort      (abort),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow),
    .drop_count (drop_count),
    .level      (level)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 armed, 2 capturing.
  int         md_state = 0;
  int         md_cnt   = 0;
  int         md_idx   = 0;
  int         md_drops = 0;
  logic [7:0] md_prev  = 8'd0;
  bit         md_pv    = 1'b0;
  bit         md_ovf   = 1'b0;
  bit         md_fd    = 1'b0;
  logic [8:0] md_q[$];

  logic [8:0] pop_q[$];
  int         fd_cnt   = 0;
  int         samp_mode = 0;   // 0 ramp +1, 1 random, 2 hold
  int         rdy_mode  = 0;   // 0 low, 1 high, 2 random

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit strobe, acc, pop, take, wl, fd, full;
    strobe = (md_cnt == 0);
    pop    = (md_q.size() != 0) && m_ready;
    if (rst) begin
      md_state = 0; md_cnt = 0; md_idx = 0; md_prev = 8'd0; md_pv = 1'b0;
      md_ovf = 1'b0; md_drops = 0; md_fd = 1'b0; md_q.delete();
      return;
    end
    acc  = start && !abort && (md_state == 0);
    take = 1'b0; fd = 1'b0; wl = 1'b0;
    if (abort && md_state != 0) begin
      md_state = 0;
    end else if (md_state == 0) begin
      if (acc) md_state = 1;
    end else if (md_state == 1) begin
      if (strobe && md_pv && md_prev < P_TL && sample_in >= P_TL) begin
        take = 1'b1; md_idx = 0;
      end
    end else begin
      if (strobe) take = 1'b1;
    end
    if (take) begin
      wl = (md_idx == P_FL - 1);
      if (wl) begin fd = 1'b1; md_state = 0; md_idx = 0; end
      else begin md_state = 2; md_idx++; end
    end
    full = (md_q.size() == P_DEPTH);
    if (pop) void'(md_q.pop_front());
    if (take) begin
      if (!full || pop) md_q.push_back({wl, sample_in});
      else begin
        md_ovf = 1'b1;
        if (md_drops < 65535) md_drops++;
      end
    end
    if (acc) begin md_ovf = 1'b0; md_drops = 0; end
    if (acc || md_cnt == P_DECIM - 1) md_cnt = 0; else md_cnt++;
    if (strobe) md_prev = sample_in;
    if (acc) md_pv = 1'b0; else if (strobe) md_pv = 1'b1;
    md_fd = fd;
  endtask

  task automatic compare_all();
    bit         ev;
    logic [8:0] head;
    ev   = (md_q.size() != 0);
    head = ev ? md_q[0] : 9'd0;
    chk("m_valid",    32'(m_valid),    32'(ev));
    chk("m_data",     32'(m_data),     32'(head[7:0]));
    chk("m_last",     32'(m_last),     32'(head[8]));
    chk("level",      32'(level),      32'(md_q.size()));
    chk("busy",       32'(busy),       32'(md_state != 0));
    chk("frame_done", 32'(frame_done), 32'(md_fd));
    chk("overflow",   32'(overflow),   32'(md_ovf));
    chk("drop_count", 32'(drop_count), 32'(md_drops));
  endtask

  task automatic step();
    model_edge();
    if (m_valid && m_ready) pop_q.push_back({m_last, m_data});
    @(posedge clk); #1;
    compare_all();
    if (frame_done) fd_cnt++;
  endtask

  task automatic tick();
    case (samp_mode)
      0:       sample_in = sample_in + 8'd1;
      1:       sample_in = 8'($urandom);
      default: sample_in = sample_in;
    endcase
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom);
    endcase
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int budget);
    int k;
    k = 0;
    while (fd_cnt == 0 && k < budget) begin tick(); k++; end
    chk(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_level(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (int'(level) != n && k < budget) begin tick(); k++; end
    chk(tag, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int d0, k;

    // Reset state
    rst = 1'b1; samp_mode = 2; rdy_mode = 0;
    ticks(2);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level",   32'(level),   32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    rst = 1'b0;
    tick();

    // Basic frame on a ramp, consumer always ready
    samp_mode = 0; rdy_mode = 1; sample_in = 8'd98;
    pop_q.delete(); fd_cnt = 0;
    pulse_start();
    chk("basic_busy", 32'(busy), 32'd1);
    wait_fd("basic_wait_fd", 200);
    ticks(4);
    chk("basic_count", 32'(pop_q.size()), 32'(P_FL));
    chk("basic_fd_once", 32'(fd_cnt), 32'd1);
    if (pop_q.size() == P_FL) begin
      chk("basic_first", 32'(pop_q[0][7:0] == 8'd120 || pop_q[0][7:0] == 8'd121), 32'd1);
      for (int i = 0; i < P_FL; i++) begin
        chk("basic_last", 32'(pop_q[i][8]), 32'(i == P_FL - 1));
        if (i > 0) chk("basic_step", 32'(pop_q[i][7:0] - pop_q[i-1][7:0]), 32'(P_DECIM));
      end
    end

    // Overflow with stalled consumer, then drain
    rst = 1'b1; tick(); rst = 1'b0;
    rdy_mode = 0; sample_in = 8'd98; fd_cnt = 0;
    pulse_start();
    wait_fd("ovf_wait_fd", 200);
    chk("ovf_level",  32'(level),      32'(P_DEPTH));
    chk("ovf_drops",  32'(drop_count), 32'(P_FL - P_DEPTH));
    chk("ovf_flag",   32'(overflow),   32'd1);
    chk("ovf_fd_once", 32'(fd_cnt),    32'd1);
    rdy_mode = 1; pop_q.delete();
    ticks(6);
    chk("ovf_drain_count", 32'(pop_q.size()), 32'(P_DEPTH));
    foreach (pop_q[i]) chk("ovf_drain_nolast", 32'(pop_q[i][8]), 32'd0);
    chk("ovf_drain_level", 32'(level), 32'd0);

    // Full FIFO with a write and pop on the same edge
    rdy_mode = 0; sample_in = 8'd98; fd_cnt = 0;
    pulse_start();
    chk("start_clr_drops", 32'(drop_count), 32'd0);
    chk("start_clr_ovf",   32'(overflow),   32'd0);
    k = 0;
    while (!(int'(level) == P_DEPTH && md_state == 2 && md_cnt == 0) && k < 100) begin
      tick(); k++;
    end
    chk("full_pop_wait", 32'(k < 100), 32'd1);
    d0 = int'(drop_count);
    rdy_mode = 1; tick(); rdy_mode = 0;
    chk("full_pop_level", 32'(level),      32'(P_DEPTH));
    chk("full_pop_drops", 32'(drop_count), 32'(d0));
    wait_fd("full_pop_fd", 200);
    rdy_mode = 1; ticks(6);

    // Abort mid-frame, then restart that must not trigger on first strobe
    rdy_mode = 0; sample_in = 8'd98;
    pulse_start();
    chk("restart_clr_drops", 32'(drop_count), 32'd0);
    wait_level("abort_wait_lvl3", 3, 100);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_level", 32'(level), 32'd3);
    ticks(3);
    chk("abort_keep",  32'(level), 32'd3);
    samp_mode = 2; sample_in = 8'd50;
    ticks(4);
    pulse_start();
    sample_in = 8'd200;
    tick();
    chk("rearm_no_trig_level", 32'(level), 32'd3);
    chk("rearm_busy",          32'(busy),  32'd1);
    ticks(4);
    chk("rearm_hold_level", 32'(level), 32'd3);
    abort = 1'b1; tick(); abort = 1'b0;
    rdy_mode = 1; ticks(5);
    chk("abort_drain_level", 32'(level), 32'd0);

    // Reset in the middle of a capture, then start/abort collision
    samp_mode = 0; rdy_mode = 0; sample_in = 8'd98;
    pulse_start();
    wait_level("rstmid_wait", P_DEPTH, 100);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_valid", 32'(m_valid), 32'd0);
    chk("rstmid_level", 32'(level),   32'd0);
    chk("rstmid_busy",  32'(busy),    32'd0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("collide_busy", 32'(busy), 32'd0);
    ticks(3);
    chk("collide_idle", 32'(busy), 32'd0);

    // Randomized traffic against the model
    samp_mode = 1; rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
